// File: rtl/cdp_nan_pkg.sv
// Shared constants, types and helpers for the CDP input NaN/Inf pre-processor.
package cdp_nan_pkg;

    localparam int FP16_EXP_MSB = 14;
    localparam int FP16_EXP_LSB = 10;
    localparam int FP16_MAN_W   = 10;

    localparam int INFO_LAST_W = 4;
    localparam int INFO_LAST_H = 5;
    localparam int INFO_LAST_C = 6;
    localparam logic [6:0] LAYER_END_MASK = 7'h7F;

    localparam logic [1:0] DTYPE_FP16 = 2'd2;

    typedef struct packed {
        logic [31:0] nan;
        logic [31:0] inf;
    } cnt_pair_t;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + 5'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/cdp_dp_nan_proc_lane_chk.sv
// Single FP16 lane classifier with optional NaN flush.
module cdp_nan_lane_chk
    import cdp_nan_pkg::*;
(
    input  logic [15:0] in_lane,
    input  logic        fp16_en,
    input  logic        tozero_en,
    output logic        nan,
    output logic        inf,
    output logic [15:0] out_lane
);

    logic exp_max;
    logic man_nz;

    // Sign bit is deliberately ignored: -NaN and -Inf classify the same.
    assign exp_max  = &in_lane[FP16_EXP_MSB:FP16_EXP_LSB];
    assign man_nz   = |in_lane[FP16_MAN_W-1:0];
    assign nan      = fp16_en & exp_max & man_nz;
    assign inf      = fp16_en & exp_max & ~man_nz;
    assign out_lane = (nan & tozero_en) ? 16'h0000 : in_lane;

endmodule

// File: rtl/cdp_dp_nan_proc.sv
// CDP input NaN/Inf pre-processor: classify, optional flush, per-cube
// counting with ping-pong publication to registers on layer done.
module cdp_dp_nan_proc
    import cdp_nan_pkg::*;
#(
    parameter  int LANES  = 4,
    parameter  int INFO_W = 23,
    localparam int DATA_W = LANES * 16,
    localparam int PD_W   = DATA_W + INFO_W
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rst,
    input  logic            cdp_rdma2dp_valid,
    output logic            cdp_rdma2dp_ready,
    input  logic [PD_W-1:0] cdp_rdma2dp_pd,
    input  logic            reg2dp_op_en,
    input  logic            reg2dp_nan_to_zero,
    input  logic [1:0]      reg2dp_input_data_type,
    input  logic            dp2reg_done,
    output logic            nan_preproc_pvld,
    input  logic            nan_preproc_prdy,
    output logic [PD_W-1:0] nan_preproc_pd,
    output logic [31:0]     dp2reg_nan_input_num,
    output logic [31:0]     dp2reg_inf_input_num
);

    localparam int CNT_W = $clog2(LANES + 1);

    logic [INFO_W-1:0] info;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;
    logic [LANES-1:0]  nan_vec;
    logic [LANES-1:0]  inf_vec;
    logic [CNT_W-1:0]  nan_pc;
    logic [CNT_W-1:0]  inf_pc;
    logic [31:0]       nan_sum;
    logic [31:0]       inf_sum;
    logic              ready;
    logic              load;
    logic              cube_end;
    logic              layer_end;
    logic              op_en_load;

    logic              op_en_d1_q,   op_en_d1_d;
    logic              waiting_q,    waiting_d;
    logic              fp16_en_q,    fp16_en_d;
    logic              tozero_q,     tozero_d;
    logic              pvld_q,       pvld_d;
    logic [PD_W-1:0]   pd_q,         pd_d;
    logic [31:0]       nan_cnt_q,    nan_cnt_d;
    logic [31:0]       inf_cnt_q,    inf_cnt_d;
    cnt_pair_t [1:0]   bank_q,       bank_d;
    logic              layer_flag_q, layer_flag_d;
    logic              wdma_flag_q,  wdma_flag_d;
    logic [31:0]       nan_num_q,    nan_num_d;
    logic [31:0]       inf_num_q,    inf_num_d;

    assign info       = cdp_rdma2dp_pd[PD_W-1:DATA_W];
    assign in_data    = cdp_rdma2dp_pd[DATA_W-1:0];
    assign ready      = (~pvld_q | nan_preproc_prdy) & ~waiting_q;
    assign load       = cdp_rdma2dp_valid & ready;
    assign cube_end   = &info[INFO_LAST_C:INFO_LAST_W];
    assign layer_end  = ((info[6:0] & LAYER_END_MASK) == LAYER_END_MASK) & load;
    assign op_en_load = reg2dp_op_en & ~op_en_d1_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cdp_nan_lane_chk u_chk (
            .in_lane   (in_data[16*i +: 16]),
            .fp16_en   (fp16_en_q),
            .tozero_en (tozero_q),
            .nan       (nan_vec[i]),
            .inf       (inf_vec[i]),
            .out_lane  (out_data[16*i +: 16])
        );
    end

    assign nan_pc  = CNT_W'(popcount(16'(nan_vec)));
    assign inf_pc  = CNT_W'(popcount(16'(inf_vec)));
    assign nan_sum = sat_add(nan_cnt_q, 32'(nan_pc));
    assign inf_sum = sat_add(inf_cnt_q, 32'(inf_pc));

    always_comb begin
        op_en_d1_d   = reg2dp_op_en;
        waiting_d    = waiting_q;
        fp16_en_d    = fp16_en_q;
        tozero_d     = tozero_q;
        pvld_d       = pvld_q;
        pd_d         = pd_q;
        nan_cnt_d    = nan_cnt_q;
        inf_cnt_d    = inf_cnt_q;
        bank_d       = bank_q;
        layer_flag_d = layer_flag_q;
        wdma_flag_d  = wdma_flag_q;
        nan_num_d    = nan_num_q;
        inf_num_d    = inf_num_q;

        if (op_en_load) begin
            fp16_en_d = (reg2dp_input_data_type == DTYPE_FP16);
            tozero_d  = reg2dp_nan_to_zero;
            waiting_d = 1'b0;
        end
        if (layer_end) begin
            waiting_d = 1'b1;
        end

        if (load) begin
            pvld_d = 1'b1;
            pd_d   = {info, out_data};
        end else if (nan_preproc_prdy) begin
            pvld_d = 1'b0;
        end

        if (load) begin
            if (cube_end) begin
                bank_d[layer_flag_q] = '{nan: nan_sum, inf: inf_sum};
                nan_cnt_d    = '0;
                inf_cnt_d    = '0;
                layer_flag_d = ~layer_flag_q;
            end else begin
                nan_cnt_d = nan_sum;
                inf_cnt_d = inf_sum;
            end
        end

        // Reading bank_d gives write-through when a snapshot lands this cycle.
        if (dp2reg_done) begin
            nan_num_d   = bank_d[wdma_flag_q].nan;
            inf_num_d   = bank_d[wdma_flag_q].inf;
            wdma_flag_d = ~wdma_flag_q;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            op_en_d1_q   <= 1'b0;
            waiting_q    <= 1'b1;
            fp16_en_q    <= 1'b0;
            tozero_q     <= 1'b0;
            pvld_q       <= 1'b0;
            pd_q         <= '0;
            nan_cnt_q    <= '0;
            inf_cnt_q    <= '0;
            bank_q       <= '0;
            layer_flag_q <= 1'b0;
            wdma_flag_q  <= 1'b0;
            nan_num_q    <= '0;
            inf_num_q    <= '0;
        end else begin
            op_en_d1_q   <= op_en_d1_d;
            waiting_q    <= waiting_d;
            fp16_en_q    <= fp16_en_d;
            tozero_q     <= tozero_d;
            pvld_q       <= pvld_d;
            pd_q         <= pd_d;
            nan_cnt_q    <= nan_cnt_d;
            inf_cnt_q    <= inf_cnt_d;
            bank_q       <= bank_d;
            layer_flag_q <= layer_flag_d;
            wdma_flag_q  <= wdma_flag_d;
            nan_num_q    <= nan_num_d;
            inf_num_q    <= inf_num_d;
        end
    end

    assign cdp_rdma2dp_ready    = ready;
    assign nan_preproc_pvld     = pvld_q;
    assign nan_preproc_pd       = pd_q;
    assign dp2reg_nan_input_num = nan_num_q;
    assign dp2reg_inf_input_num = inf_num_q;

endmodule

// File: tb/tb_cdp_dp_nan_proc.sv
// Randomised self-checking bench for cdp_dp_nan_proc against a queue-based
// behavioural model of classification, flushing and per-cube counting.
module tb_cdp_dp_nan_proc;

    localparam int LANES  = 4;
    localparam int INFO_W = 23;
    localparam int DATA_W = LANES * 16;
    localparam int PD_W   = DATA_W + INFO_W;

    typedef logic [PD_W-1:0] pd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              ready;
    pd_t               pd_in;
    logic              op_en;
    logic              tozero;
    logic [1:0]        dtype;
    logic              done;
    logic              pvld;
    logic              prdy;
    pd_t               pd;
    logic [31:0]       nan_num;
    logic [31:0]       inf_num;

    int checks = 0;
    int errors = 0;

    pd_t    exp_q[$];
    pd_t    seen_q[$];
    longint snap_nan_q[$];
    longint snap_inf_q[$];
    longint m_nan;
    longint m_inf;
    bit     m_fp16;
    bit     m_tz;
    pd_t    mon_exp;

    cdp_dp_nan_proc #(.LANES(LANES), .INFO_W(INFO_W)) dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .cdp_rdma2dp_valid      (valid),
        .cdp_rdma2dp_ready      (ready),
        .cdp_rdma2dp_pd         (pd_in),
        .reg2dp_op_en           (op_en),
        .reg2dp_nan_to_zero     (tozero),
        .reg2dp_input_data_type (dtype),
        .dp2reg_done            (done),
        .nan_preproc_pvld       (pvld),
        .nan_preproc_prdy       (prdy),
        .nan_preproc_pd         (pd),
        .dp2reg_nan_input_num   (nan_num),
        .dp2reg_inf_input_num   (inf_num)
    );

    always #5 clk = ~clk;

    // Output scoreboard: every consumed beat must match the model in order.
    always @(negedge clk) begin
        if (!rst && pvld && prdy) begin
            seen_q.push_back(pd);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_beat unexpected got=%h", pd);
            end else begin
                mon_exp = exp_q.pop_front();
                if (pd !== mon_exp) begin
                    errors++;
                    $display("FAIL out_beat got=%h exp=%h", pd, mon_exp);
                end
            end
        end
    end

    function automatic pd_t m_proc(input pd_t p, output int nn, output int ni);
        pd_t         r;
        logic [15:0] lane;
        int          ex;
        int          mn;
        r  = p;
        nn = 0;
        ni = 0;
        for (int i = 0; i < LANES; i++) begin
            lane = p[16*i +: 16];
            ex   = (int'(lane) / 1024) % 32;
            mn   = int'(lane) % 1024;
            if (m_fp16 && ex == 31) begin
                if (mn != 0) begin
                    nn++;
                    if (m_tz) r[16*i +: 16] = 16'h0000;
                end else begin
                    ni++;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_lane();
        logic [15:0] l;
        l = 16'($urandom);
        case ($urandom_range(0, 3))
            0: l[14:0] = 15'h7C00;
            1: begin
                l[14:10] = 5'h1F;
                l[0]     = 1'b1;
            end
            default: ;
        endcase
        return l;
    endfunction

    function automatic logic [DATA_W-1:0] rand_beat();
        logic [DATA_W-1:0] b;
        for (int i = 0; i < LANES; i++) b[16*i +: 16] = rand_lane();
        return b;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_layer(input logic [1:0] dt, input bit tz);
        op_en = 1'b0;
        cyc();
        cyc();
        dtype  = dt;
        tozero = tz;
        op_en  = 1'b1;
        m_fp16 = (dt == 2'd2);
        m_tz   = tz;
        cyc();
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] lanes, input bit cube, input bit layer);
        logic [INFO_W-1:0] info;
        pd_t p;
        int  nn;
        int  ni;
        bit  ok;
        info = INFO_W'($urandom);
        if (layer) info[6:0] = 7'h7F;
        else if (cube) begin
            info[6:4] = 3'b111;
            info[0]   = 1'b0;
        end else info[6] = 1'b0;
        p     = {info, lanes};
        valid = 1'b1;
        pd_in = p;
        ok    = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout ready=%b exp=1", ready);
        end else begin
            exp_q.push_back(m_proc(p, nn, ni));
            m_nan = m_nan + nn;
            m_inf = m_inf + ni;
            if (m_nan > 64'hFFFF_FFFF) m_nan = 64'hFFFF_FFFF;
            if (m_inf > 64'hFFFF_FFFF) m_inf = 64'hFFFF_FFFF;
            if (cube) begin
                snap_nan_q.push_back(m_nan);
                snap_inf_q.push_back(m_inf);
                m_nan = 0;
                m_inf = 0;
            end
        end
        @(posedge clk);
        #2;
        valid = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cyc();
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 0; pd_in = '0; op_en = 0; tozero = 0; dtype = 0; done = 0; prdy = 1;
        repeat (3) cyc();
        checks++;
        if (ready !== 1'b0 || pvld !== 1'b0 || pd !== '0) begin
            errors++;
            $display("FAIL reset_hs ready=%b pvld=%b pd=%h exp=0", ready, pvld, pd);
        end
        checks++;
        if (nan_num !== 32'd0 || inf_num !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt nan=%h inf=%h exp=0", nan_num, inf_num);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_waiting ready=%b exp=0", ready);
        end
        m_nan = 0;
        m_inf = 0;
    endtask

    task automatic test_flush();
        longint en, ei;
        set_layer(2'd2, 1'b1);
        seen_q.delete();
        send_beat({16'h7C01, 16'h7C00, 16'hFC00, 16'h3C00}, 1'b0, 1'b0);
        send_beat({16'h0000, 16'hFE00, 16'h0000, 16'h0000}, 1'b1, 1'b1);
        cyc();
        cyc();
        checks++;
        if (seen_q.size() < 1 || seen_q[0][DATA_W-1:0] !== 64'h0000_7C00_FC00_3C00) begin
            errors++;
            $display("FAIL flush_data got=%h exp=00007c00fc003c00",
                     seen_q.size() > 0 ? seen_q[0][DATA_W-1:0] : 64'hx);
        end
        pulse_done();
        en = snap_nan_q.pop_front();
        ei = snap_inf_q.pop_front();
        checks++;
        if (nan_num !== 32'd2 || inf_num !== 32'd2 || nan_num !== en[31:0] || inf_num !== ei[31:0]) begin
            errors++;
            $display("FAIL flush_cnt nan=%0d inf=%0d exp=2/2", nan_num, inf_num);
        end
    endtask

    task automatic test_passthru();
        longint en, ei;
        set_layer(2'd2, 1'b0);
        seen_q.delete();
        send_beat({16'h7C01, 16'h7C00, 16'hFC00, 16'h3C00}, 1'b0, 1'b0);
        send_beat({16'h0000, 16'hFE00, 16'h0000, 16'h0000}, 1'b1, 1'b1);
        cyc();
        cyc();
        checks++;
        if (seen_q.size() < 1 || seen_q[0][DATA_W-1:0] !== 64'h7C01_7C00_FC00_3C00) begin
            errors++;
            $display("FAIL pass_data got=%h exp=7c017c00fc003c00",
                     seen_q.size() > 0 ? seen_q[0][DATA_W-1:0] : 64'hx);
        end
        pulse_done();
        en = snap_nan_q.pop_front();
        ei = snap_inf_q.pop_front();
        checks++;
        if (nan_num !== 32'd2 || inf_num !== 32'd2 || nan_num !== en[31:0] || inf_num !== ei[31:0]) begin
            errors++;
            $display("FAIL pass_cnt nan=%0d inf=%0d exp=2/2", nan_num, inf_num);
        end
    endtask

    task automatic test_back_to_back();
        pd_t    held;
        time    t0;
        longint en, ei;
        set_layer(2'd2, 1'($urandom_range(0, 1)));
        seen_q.delete();
        prdy = 1'b0;
        send_beat(rand_beat(), 1'b0, 1'b0);
        valid = 1'b1;
        pd_in = {INFO_W'(0), rand_beat()};
        held  = pd;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0 || pvld !== 1'b1 || pd !== held) begin
                errors++;
                $display("FAIL stall c=%0d ready=%b pvld=%b pd=%h exp=0/1/%h", c, ready, pvld, pd, held);
            end
            @(posedge clk);
            #2;
        end
        prdy = 1'b1;
        t0 = $time;
        for (int k = 0; k < 8; k++) send_beat(rand_beat(), k == 7, k == 7);
        checks++;
        if ($time - t0 != 80) begin
            errors++;
            $display("FAIL throughput time=%0t exp=80", $time - t0);
        end
        cyc();
        cyc();
        checks++;
        if (seen_q.size() != 9 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain seen=%0d pending=%0d exp=9/0", seen_q.size(), exp_q.size());
        end
        pulse_done();
        en = snap_nan_q.pop_front();
        ei = snap_inf_q.pop_front();
        checks++;
        if (nan_num !== en[31:0] || inf_num !== ei[31:0]) begin
            errors++;
            $display("FAIL b2b_cnt nan=%0d inf=%0d exp=%0d/%0d", nan_num, inf_num, en, ei);
        end
    endtask

    task automatic test_op_en();
        longint en, ei;
        set_layer(2'd2, 1'b1);
        send_beat(rand_beat(), 1'b1, 1'b1);
        valid = 1'b1;
        pd_in = {INFO_W'(0), rand_beat()};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b0) begin
                errors++;
                $display("FAIL gate_hold c=%0d ready=%b exp=0", c, ready);
            end
            @(posedge clk);
            #2;
        end
        op_en = 1'b0;
        cyc();
        cyc();
        op_en = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL gate_edge ready=%b exp=0", ready);
        end
        @(posedge clk);
        #2;
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL gate_open ready=%b exp=1", ready);
        end
        valid = 1'b0;
        @(posedge clk);
        #2;
        send_beat(rand_beat(), 1'b1, 1'b1);
        cyc();
        for (int k = 0; k < 2; k++) begin
            pulse_done();
            en = snap_nan_q.pop_front();
            ei = snap_inf_q.pop_front();
            checks++;
            if (nan_num !== en[31:0] || inf_num !== ei[31:0]) begin
                errors++;
                $display("FAIL gate_cnt k=%0d nan=%0d inf=%0d exp=%0d/%0d", k, nan_num, inf_num, en, ei);
            end
        end
    endtask

    task automatic test_int8();
        set_layer(2'd0, 1'b1);
        seen_q.delete();
        send_beat({4{16'h7C01}}, 1'b1, 1'b1);
        cyc();
        cyc();
        checks++;
        if (seen_q.size() < 1 || seen_q[0][DATA_W-1:0] !== {4{16'h7C01}}) begin
            errors++;
            $display("FAIL int8_data got=%h exp=7c017c017c017c01",
                     seen_q.size() > 0 ? seen_q[0][DATA_W-1:0] : 64'hx);
        end
        pulse_done();
        void'(snap_nan_q.pop_front());
        void'(snap_inf_q.pop_front());
        checks++;
        if (nan_num !== 32'd0 || inf_num !== 32'd0) begin
            errors++;
            $display("FAIL int8_cnt nan=%0d inf=%0d exp=0/0", nan_num, inf_num);
        end
    endtask

    task automatic test_two_cubes();
        longint en, ei;
        set_layer(2'd2, 1'($urandom_range(0, 1)));
        for (int k = 0; k < 4; k++) send_beat(rand_beat(), k == 3, 1'b0);
        for (int k = 0; k < 3; k++) send_beat(rand_beat(), k == 2, k == 2);
        cyc();
        for (int k = 0; k < 2; k++) begin
            pulse_done();
            en = snap_nan_q.pop_front();
            ei = snap_inf_q.pop_front();
            checks++;
            if (nan_num !== en[31:0] || inf_num !== ei[31:0]) begin
                errors++;
                $display("FAIL cube%0d_cnt nan=%0d inf=%0d exp=%0d/%0d", k, nan_num, inf_num, en, ei);
            end
        end
    endtask

    task automatic test_saturate();
        longint en;
        set_layer(2'd2, 1'b0);
        force dut.nan_cnt_q = 32'hFFFF_FFFE;
        m_nan = 64'hFFFF_FFFE;
        send_beat({4{16'h7E00}}, 1'b1, 1'b1);
        force dut.nan_cnt_q = 32'h0;
        #1;
        release dut.nan_cnt_q;
        cyc();
        pulse_done();
        en = snap_nan_q.pop_front();
        void'(snap_inf_q.pop_front());
        checks++;
        if (nan_num !== 32'hFFFF_FFFF || nan_num !== en[31:0]) begin
            errors++;
            $display("FAIL saturate nan=%h exp=ffffffff", nan_num);
        end
    endtask

    task automatic test_reset_mid();
        set_layer(2'd2, 1'b1);
        prdy = 1'b0;
        send_beat(rand_beat(), 1'b0, 1'b0);
        valid = 1'b1;
        pd_in = {INFO_W'(0), rand_beat()};
        op_en = 1'b0;
        rst   = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b0 || pvld !== 1'b0 || pd !== '0) begin
            errors++;
            $display("FAIL rstmid_hs ready=%b pvld=%b pd=%h exp=0", ready, pvld, pd);
        end
        checks++;
        if (nan_num !== 32'd0 || inf_num !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_cnt nan=%h inf=%h exp=0", nan_num, inf_num);
        end
        exp_q.delete();
        m_nan = 0;
        m_inf = 0;
        cyc();
        rst  = 1'b0;
        prdy = 1'b1;
        cyc();
        cyc();
        checks++;
        if (ready !== 1'b0 || pvld !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after ready=%b pvld=%b exp=0/0", ready, pvld);
        end
        valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_flush();
        test_passthru();
        test_back_to_back();
        test_op_en();
        test_int8();
        test_two_cubes();
        test_saturate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
